// File: rtl/mem_request_unit.sv
// Memory-request sequencer: turns decoded load/store/halt into memory-port enables and PC strobes.
// Optional stalled-cycle counter port enabled by defining REQ_STALL_STATS_EN.
module mem_request_unit #(
   parameter int WAIT_LIMIT = 255,
   parameter int CNT_W      = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             mem_halt,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             pc_en,
   output logic             halt,
   output logic             req_err,
   output logic [1:0]       state_dbg
`ifdef REQ_STALL_STATS_EN
   ,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   // Counter must be at least one bit wide even when the watchdog is disabled.
   localparam int WCW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_DATA   = 2'd1,
      S_HALTED = 2'd2,
      S_ERR    = 2'd3
   } state_t;

   state_t           state, state_n;
   logic             dren_n, dwen_n;
   logic [WCW-1:0]   wait_cnt, wait_cnt_n;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= S_FETCH;
         dmemREN  <= 1'b0;
         dmemWEN  <= 1'b0;
         wait_cnt <= '0;
      end else begin
         state    <= state_n;
         dmemREN  <= dren_n;
         dmemWEN  <= dwen_n;
         wait_cnt <= wait_cnt_n;
      end
   end

   always_comb begin
      state_n    = state;
      dren_n     = dmemREN;
      dwen_n     = dmemWEN;
      wait_cnt_n = wait_cnt;
      pc_en      = 1'b0;
      case (state)
         S_FETCH: begin
            if (ihit) begin
               if (mem_halt) begin
                  state_n = S_HALTED;
               end else if (mem_read || mem_write) begin
                  // Store wins when both request bits are set.
                  state_n    = S_DATA;
                  dwen_n     = mem_write;
                  dren_n     = mem_read & ~mem_write;
                  wait_cnt_n = '0;
               end else begin
                  pc_en = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (dhit) begin
               pc_en      = 1'b1;
               state_n    = S_FETCH;
               dren_n     = 1'b0;
               dwen_n     = 1'b0;
               wait_cnt_n = '0;
            end else if (WAIT_LIMIT != 0) begin
               wait_cnt_n = wait_cnt + 1'b1;
               if (wait_cnt == WAIT_LAST) begin
                  state_n = S_ERR;
                  dren_n  = 1'b0;
                  dwen_n  = 1'b0;
               end
            end
         end
         default: begin
            dren_n = 1'b0;
            dwen_n = 1'b0;
         end
      endcase
   end

   assign imemREN   = (state == S_FETCH);
   assign halt      = (state == S_HALTED) || (state == S_ERR);
   assign req_err   = (state == S_ERR);
   assign state_dbg = state;

`ifdef REQ_STALL_STATS_EN
   // Counts cycles where the PC was held while still doing useful work; saturates.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt <= '0;
      end else if ((state == S_FETCH || state == S_DATA) && !pc_en && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_request_unit.sv
// Bench for mem_request_unit: default instance (a) and WAIT_LIMIT=4 instance (b) share stimulus.
module tb_mem_request_unit;

   logic CLK = 1'b0;
   logic nRST = 1'b0;
   logic ihit = 1'b0, dhit = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_halt = 1'b0;

   logic imem_a, dren_a, dwen_a, pc_a, halt_a, err_a;
   logic imem_b, dren_b, dwen_b, pc_b, halt_b, err_b;
   logic [1:0] st_a, st_b;
`ifdef REQ_STALL_STATS_EN
   logic [15:0] stall_a, stall_b;
`endif

   int checks = 0;
   int failures = 0;
   logic [11:0] exp_q[$];
   logic [11:0] got, want;

   wire [5:0] obs_a = {imem_a, dren_a, dwen_a, pc_a, halt_a, err_a};
   wire [5:0] obs_b = {imem_b, dren_b, dwen_b, pc_b, halt_b, err_b};

   always #5 CLK = ~CLK;

   mem_request_unit dut_a (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .mem_read(mem_read), .mem_write(mem_write), .mem_halt(mem_halt),
      .imemREN(imem_a), .dmemREN(dren_a), .dmemWEN(dwen_a), .pc_en(pc_a),
      .halt(halt_a), .req_err(err_a), .state_dbg(st_a)
`ifdef REQ_STALL_STATS_EN
      , .stall_cnt(stall_a)
`endif
   );

   mem_request_unit #(.WAIT_LIMIT(4)) dut_b (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .mem_read(mem_read), .mem_write(mem_write), .mem_halt(mem_halt),
      .imemREN(imem_b), .dmemREN(dren_b), .dmemWEN(dwen_b), .pc_en(pc_b),
      .halt(halt_b), .req_err(err_b), .state_dbg(st_b)
`ifdef REQ_STALL_STATS_EN
      , .stall_cnt(stall_b)
`endif
   );

   // Stimulus vector order: {ihit, dhit, mem_read, mem_write, mem_halt}
   task automatic drive(input logic [4:0] s);
      {ihit, dhit, mem_read, mem_write, mem_halt} = s;
   endtask

   // Leaves the DUTs freshly out of reset, 1 time unit after a posedge.
   task automatic do_reset();
      nRST = 1'b0;
      drive(5'b00000);
      repeat (2) @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      drive(5'b00000);
      #1;
      exp_q.push_back({6'b100000, 6'b100000});
      got = {obs_a, obs_b};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL reset_async got=%b want=%b", got, want);
      end
      checks++;
      if ({st_a, st_b} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_state got=%b want=0000", {st_a, st_b});
      end
`ifdef REQ_STALL_STATS_EN
      checks++;
      if (stall_a !== 16'd0) begin
         failures++;
         $display("FAIL reset_stall got=%0d want=0", stall_a);
      end
`endif
      do_reset();
   endtask

   task automatic test_fetch();
      logic [4:0]  st[4];
      logic [11:0] ex[4];
      st = '{5'b10000, 5'b00000, 5'b01000, 5'b10000};
      ex = '{{6'b100100, 6'b100100}, {6'b100000, 6'b100000},
             {6'b100000, 6'b100000}, {6'b100100, 6'b100100}};
      for (int i = 0; i < 4; i++) begin
         drive(st[i]);
         exp_q.push_back(ex[i]);
         @(negedge CLK);
         got = {obs_a, obs_b};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL fetch c%0d got=%b want=%b", i, got, want);
         end
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_load();
      logic [4:0]  st[6];
      logic [11:0] ex[6];
      do_reset();
      st = '{5'b10100, 5'b00000, 5'b00000, 5'b10000, 5'b01000, 5'b00000};
      ex = '{{6'b100000, 6'b100000}, {6'b010000, 6'b010000}, {6'b010000, 6'b010000},
             {6'b010000, 6'b010000}, {6'b010100, 6'b010100}, {6'b100000, 6'b100000}};
      for (int i = 0; i < 6; i++) begin
         drive(st[i]);
         exp_q.push_back(ex[i]);
         @(negedge CLK);
         got = {obs_a, obs_b};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL load c%0d got=%b want=%b", i, got, want);
         end
`ifdef REQ_STALL_STATS_EN
         if (i >= 4) begin
            checks++;
            if (stall_a !== 16'd4) begin
               failures++;
               $display("FAIL load_stall c%0d got=%0d want=4", i, stall_a);
            end
         end
`endif
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_store();
      logic [4:0]  st[7];
      logic [11:0] ex[7];
      st = '{5'b10110, 5'b00000, 5'b01000, 5'b00000, 5'b10010, 5'b11000, 5'b00000};
      ex = '{{6'b100000, 6'b100000}, {6'b001000, 6'b001000}, {6'b001100, 6'b001100},
             {6'b100000, 6'b100000}, {6'b100000, 6'b100000}, {6'b001100, 6'b001100},
             {6'b100000, 6'b100000}};
      for (int i = 0; i < 7; i++) begin
         drive(st[i]);
         exp_q.push_back(ex[i]);
         @(negedge CLK);
         got = {obs_a, obs_b};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL store c%0d got=%b want=%b", i, got, want);
         end
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_halt();
      logic [2:0] r;
      do_reset();
      // Halt outranks the simultaneous load request.
      drive(5'b10101);
      exp_q.push_back({6'b100000, 6'b100000});
      @(negedge CLK);
      got = {obs_a, obs_b};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL halt_entry got=%b want=%b", got, want);
      end
      @(posedge CLK);
      #1;
      for (int i = 0; i < 11; i++) begin
         r = 3'($urandom_range(0, 7));
         drive({1'b1, r[0], r[1], r[2], 1'b0});
         exp_q.push_back({6'b000010, 6'b000010});
         @(negedge CLK);
         got = {obs_a, obs_b};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL halt_hold c%0d got=%b want=%b", i, got, want);
         end
         @(posedge CLK);
         #1;
      end
`ifdef REQ_STALL_STATS_EN
      checks++;
      if (stall_a !== 16'd1) begin
         failures++;
         $display("FAIL halt_stall_frozen got=%0d want=1", stall_a);
      end
`endif
   endtask

   task automatic test_watchdog();
      logic [4:0]  st[8];
      logic [11:0] ex[8];
      do_reset();
      st = '{5'b10100, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b11000, 5'b00000};
      ex = '{{6'b100000, 6'b100000}, {6'b010000, 6'b010000}, {6'b010000, 6'b010000},
             {6'b010000, 6'b010000}, {6'b010000, 6'b010000}, {6'b010000, 6'b000011},
             {6'b010100, 6'b000011}, {6'b100000, 6'b000011}};
      for (int i = 0; i < 8; i++) begin
         drive(st[i]);
         exp_q.push_back(ex[i]);
         @(negedge CLK);
         got = {obs_a, obs_b};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL watchdog c%0d got=%b want=%b", i, got, want);
         end
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0]  st[16];
      logic [11:0] ex[16];
      do_reset();
      // Two 3-stall loads in a row must not trip the 4-cycle watchdog.
      st = '{5'b10000, 5'b10000, 5'b10000, 5'b10100, 5'b00000, 5'b00000, 5'b00000, 5'b01000,
             5'b10100, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b10010, 5'b01000, 5'b10000};
      ex = '{{6'b100100, 6'b100100}, {6'b100100, 6'b100100}, {6'b100100, 6'b100100},
             {6'b100000, 6'b100000}, {6'b010000, 6'b010000}, {6'b010000, 6'b010000},
             {6'b010000, 6'b010000}, {6'b010100, 6'b010100}, {6'b100000, 6'b100000},
             {6'b010000, 6'b010000}, {6'b010000, 6'b010000}, {6'b010000, 6'b010000},
             {6'b010100, 6'b010100}, {6'b100000, 6'b100000}, {6'b001100, 6'b001100},
             {6'b100100, 6'b100100}};
      for (int i = 0; i < 16; i++) begin
         drive(st[i]);
         exp_q.push_back(ex[i]);
         @(negedge CLK);
         got = {obs_a, obs_b};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL b2b c%0d got=%b want=%b", i, got, want);
         end
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      drive(5'b10100);
      @(posedge CLK);
      #1;
      drive(5'b00000);
      exp_q.push_back({6'b010000, 6'b010000});
      @(negedge CLK);
      got = {obs_a, obs_b};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL mid_reset_pre got=%b want=%b", got, want);
      end
      #2;
      nRST = 1'b0;
      exp_q.push_back({6'b100000, 6'b100000});
      #1;
      got = {obs_a, obs_b};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL mid_reset_async got=%b want=%b", got, want);
      end
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      drive(5'b10000);
      exp_q.push_back({6'b100100, 6'b100100});
      @(negedge CLK);
      got = {obs_a, obs_b};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL mid_reset_resume got=%b want=%b", got, want);
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_load();
      test_store();
      test_halt();
      test_watchdog();
      test_back_to_back();
      test_mid_reset();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain got=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
